// File: rtl/bcd_display_mux.sv
// Latches a 2-digit BCD value and scans it onto a multiplexed 7-segment display, flashing on change.
// Outputs registered one cycle after scan/FSM state; ena=0 freezes all state and blanks the display.
module bcd_display_mux #(
  parameter int SCAN_DIV       = 64,
  parameter int BLINK_TICKS    = 8192,
  parameter int FLASH_CYCLES   = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] bcd_in,
  input  logic       load,
  output logic [6:0] seg_out,
  output logic [1:0] dig_sel,
  output logic       busy
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int FW = $clog2(FLASH_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST    = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_TICKS - 1);
  localparam logic [FW-1:0] FLASH_INIT   = FW'(FLASH_CYCLES);
  localparam logic [6:0]    SEG_OFF      = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {IDLE, FLASH_OFF, FLASH_ON} state_t;

  state_t        state;
  logic [7:0]    held;
  logic [SW-1:0] scan_cnt;
  logic          slot;
  logic [BW-1:0] blink_cnt;
  logic [FW-1:0] flash_left;

  logic [3:0] nib;
  logic [6:0] seg_raw;
  logic [6:0] seg_nxt;
  logic [1:0] dig_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    nib     = slot ? held[7:4] : held[3:0];
    // A zero tens digit stays dark, but its slot timing is unchanged
    seg_raw = (slot && held[7:4] == 4'd0) ? 7'h00 : decode(nib);
    seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    dig_nxt = 2'b00;
    if (scan_cnt != '0 && state != FLASH_OFF)
      dig_nxt = slot ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      held       <= 8'h01;
      scan_cnt   <= '0;
      slot       <= 1'b0;
      blink_cnt  <= '0;
      flash_left <= '0;
      seg_out    <= SEG_OFF;
      dig_sel    <= 2'b00;
      busy       <= 1'b0;
    end else if (ena) begin
      seg_out <= seg_nxt;
      dig_sel <= dig_nxt;

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        slot     <= ~slot;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (load)
        held <= bcd_in;

      // A changed value always restarts the flash at full length
      if (load && bcd_in != held) begin
        state      <= FLASH_OFF;
        blink_cnt  <= BLINK_RELOAD;
        flash_left <= FLASH_INIT;
        busy       <= 1'b1;
      end else begin
        case (state)
          FLASH_OFF: begin
            if (blink_cnt == '0) begin
              state     <= FLASH_ON;
              blink_cnt <= BLINK_RELOAD;
            end else begin
              blink_cnt <= blink_cnt - 1'b1;
            end
          end
          FLASH_ON: begin
            if (blink_cnt == '0) begin
              flash_left <= flash_left - 1'b1;
              blink_cnt  <= BLINK_RELOAD;
              if (flash_left == FW'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= FLASH_OFF;
              end
            end else begin
              blink_cnt <= blink_cnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end else begin
      seg_out <= SEG_OFF;
      dig_sel <= 2'b00;
    end
  end

endmodule
